// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the SR command conditioner.
// The arbiter result enum and the conflict counter limits live here so the
// top and any future users agree on encodings.
package sr_cmd_pkg;

  // Result of arbitrating the two channel requests in a given cycle
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_SET  = 2'd1,
    CMD_CLR  = 2'd2
  } sr_cmd_e;

  localparam int                        CONFLICT_CNT_W   = 8;
  localparam logic [CONFLICT_CNT_W-1:0] CONFLICT_CNT_MAX = 8'hFF;

endpackage

// File: rtl/sr_debounce.sv
// One request channel: 2-flop synchroniser, counter debouncer and
// rising-edge detector. req is a one-cycle pulse per accepted rising level.
module sr_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic req
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             q1;
  logic             q2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // Two-stage synchroniser; only q2 is trusted downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= raw;
      q2 <= q1;
    end
  end

  // Accept a new level only after it differs from stable for DEBOUNCE_CYCLES
  // consecutive cycles; any return to the stable level restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (q2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= q2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
    end
  end

  assign req = stable & ~stable_d;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// SR command conditioner: turns raw set/clear requests into clean,
// mutually exclusive one-cycle S/R command pulses for an SR flop.
// Optional feature macro: SR_CONFLICT_CNT_EN adds an 8-bit saturating
// count of conflict pulses on port conflict_cnt.
module sr_cmd_conditioner
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int RST_PRIORITY    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_raw,
  input  logic clr_raw,
  output logic s_out,
  output logic r_out,
  output logic conflict
`ifdef SR_CONFLICT_CNT_EN
  ,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
`endif
);

  logic    set_req;
  logic    clr_req;
  sr_cmd_e cmd_next;
  logic    conflict_next;

  sr_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_set_db (
    .clk(clk),
    .rst(rst),
    .raw(set_raw),
    .req(set_req)
  );

  sr_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_clr_db (
    .clk(clk),
    .rst(rst),
    .raw(clr_raw),
    .req(clr_req)
  );

  // Arbitrate same-cycle requests; the loser is dropped, never queued
  always_comb begin
    cmd_next      = CMD_NONE;
    conflict_next = 1'b0;
    case ({set_req, clr_req})
      2'b10:   cmd_next = CMD_SET;
      2'b01:   cmd_next = CMD_CLR;
      2'b11: begin
        conflict_next = 1'b1;
        cmd_next      = (RST_PRIORITY != 0) ? CMD_CLR : CMD_SET;
      end
      default: cmd_next = CMD_NONE;
    endcase
  end

  // Registered command outputs; the one-hot decode keeps s_out & r_out == 0
  always_ff @(posedge clk) begin
    if (rst) begin
      s_out    <= 1'b0;
      r_out    <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s_out    <= (cmd_next == CMD_SET);
      r_out    <= (cmd_next == CMD_CLR);
      conflict <= conflict_next;
    end
  end

`ifdef SR_CONFLICT_CNT_EN
  // Saturating tally of conflict pulses, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != CONFLICT_CNT_MAX)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule
